// File: rtl/arith_pkg.sv
// Shared constants for the add/subtract datapath stage.
package arith_pkg;

    // Operand/result width used throughout the datapath.
    localparam int WIDTH = 32;

    // Bits per carry-lookahead group.
    localparam int CLA_GROUP = 4;

    // Function select encodings.
    localparam logic FS_ADD = 1'b0;
    localparam logic FS_SUB = 1'b1;

    // Signedness encodings.
    localparam logic SF_UNSIGNED = 1'b0;
    localparam logic SF_SIGNED   = 1'b1;

endpackage

// File: rtl/arith_unit_32_cla_adder.sv
// Two-level carry-lookahead adder: 4-bit groups with their own generate and
// propagate, and a flattened lookahead network producing every group carry
// directly from the group terms and the carry-in.
module cla_adder
    import arith_pkg::*;
#(
    parameter int WIDTH = arith_pkg::WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NGROUPS = WIDTH / CLA_GROUP;

    logic [WIDTH-1:0]   bit_g;
    logic [WIDTH-1:0]   bit_p;
    logic [NGROUPS-1:0] grp_g;
    logic [NGROUPS-1:0] grp_p;
    logic [NGROUPS:0]   grp_c;

    assign bit_g = a & b;
    assign bit_p = a ^ b;

    genvar gi;
    generate
        for (gi = 0; gi < NGROUPS; gi++) begin : g_group
            localparam int L = gi * CLA_GROUP;
            logic [3:0] g;
            logic [3:0] p;
            logic [3:0] c;

            assign g = bit_g[L+3:L];
            assign p = bit_p[L+3:L];

            // Group generate/propagate feeding the second-level lookahead.
            assign grp_g[gi] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                             | (p[3] & p[2] & p[1] & g[0]);
            assign grp_p[gi] = &p;

            // Bit carries inside the group, each expanded from the group carry-in.
            assign c[0] = grp_c[gi];
            assign c[1] = g[0] | (p[0] & grp_c[gi]);
            assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & grp_c[gi]);
            assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                        | (p[2] & p[1] & p[0] & grp_c[gi]);

            assign sum[L+3:L] = p ^ c;
        end
    endgenerate

    // Second-level lookahead: each group carry is a sum of products of group
    // generates/propagates and cin, so no carry ripples between groups.
    always_comb begin
        logic acc;
        logic prod;
        grp_c    = '0;
        grp_c[0] = cin;
        for (int j = 1; j <= NGROUPS; j++) begin
            acc = cin;
            for (int m = 0; m < j; m++) begin
                acc = acc & grp_p[m];
            end
            for (int k = 0; k < j; k++) begin
                prod = grp_g[k];
                for (int m = k + 1; m < j; m++) begin
                    prod = prod & grp_p[m];
                end
                acc = acc | prod;
            end
            grp_c[j] = acc;
        end
    end

    assign cout = grp_c[NGROUPS];

endmodule

// File: rtl/arith_unit_32.sv
// Registered 32-bit add/subtract stage with a signed/unsigned overflow flag.
module arith_unit_32
    import arith_pkg::*;
#(
    parameter int WIDTH = arith_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             FS,
    input  logic             SF,
    output logic [WIDTH-1:0] out,
    output logic             OF
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum_next;
    logic             carry;
    logic             of_next;
    logic [WIDTH-1:0] out_reg;
    logic             of_reg;

    // Subtract is A + ~B + 1: invert B here and feed FS in as carry-in.
    assign b_eff = (FS == FS_SUB) ? ~B : B;

    cla_adder #(
        .WIDTH (WIDTH)
    ) u_cla (
        .a    (A),
        .b    (b_eff),
        .cin  (FS),
        .sum  (sum_next),
        .cout (carry)
    );

    // Overflow: carry/borrow for unsigned, sign-rule for two's complement.
    always_comb begin
        logic a_msb;
        logic b_msb;
        logic s_msb;
        logic of_unsigned;
        logic of_signed;
        a_msb       = A[WIDTH-1];
        b_msb       = B[WIDTH-1];
        s_msb       = sum_next[WIDTH-1];
        of_unsigned = (FS == FS_SUB) ? ~carry : carry;
        if (FS == FS_SUB) begin
            of_signed = (a_msb != b_msb) && (s_msb != a_msb);
        end else begin
            of_signed = (a_msb == b_msb) && (s_msb != a_msb);
        end
        of_next = (SF == SF_SIGNED) ? of_signed : of_unsigned;
    end

    // Output registers; reset wins over the incoming sample.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_reg <= '0;
            of_reg  <= 1'b0;
        end else begin
            out_reg <= sum_next;
            of_reg  <= of_next;
        end
    end

    assign out = out_reg;
    assign OF  = of_reg;

endmodule

// File: tb/tb_arith_unit_32.sv
// Scoreboard bench for arith_unit_32: the driver pushes the expected result
// of every edge it drives; a monitor pops and compares after each edge.
module tb_arith_unit_32;

    localparam longint S_MAX = 64'sd2147483647;
    localparam longint S_MIN = -64'sd2147483648;
    localparam longint U_MAX = 64'sd4294967295;

    logic        clk;
    logic        rst_n;
    logic [31:0] A;
    logic [31:0] B;
    logic        FS;
    logic        SF;
    logic [31:0] out;
    logic        OF;

    typedef struct {
        logic [31:0] exp_out;
        logic        exp_of;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks;
    int   n_pass;

    arith_unit_32 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (A),
        .B     (B),
        .FS    (FS),
        .SF    (SF),
        .out   (out),
        .OF    (OF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: exact integer result, then range check for the chosen type.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  input logic fs, input logic sf,
                                  output logic [31:0] r, output logic of);
        longint t;
        if (sf) begin
            longint sa = longint'(signed'(a));
            longint sb = longint'(signed'(b));
            t  = fs ? sa - sb : sa + sb;
            of = (t > S_MAX) || (t < S_MIN);
        end else begin
            longint ua = longint'(a);
            longint ub = longint'(b);
            t  = fs ? ua - ub : ua + ub;
            of = (t < 0) || (t > U_MAX);
        end
        r = t[31:0];
    endfunction

    // Apply one edge's worth of inputs and queue what the DUT should show after it.
    task automatic drive(input logic r, input logic [31:0] a, input logic [31:0] b,
                         input logic fs, input logic sf, input string name);
        exp_t e;
        rst_n = r;
        A     = a;
        B     = b;
        FS    = fs;
        SF    = sf;
        if (!r) begin
            e.exp_out = '0;
            e.exp_of  = 1'b0;
        end else begin
            model(a, b, fs, sf, e.exp_out, e.exp_of);
        end
        e.name = name;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: every edge with a queued expectation is checked 1 time unit later.
    always @(posedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            #1;
            n_checks++;
            if (out === e.exp_out && OF === e.exp_of) begin
                n_pass++;
                $display("ok   %s: out=%h OF=%b", e.name, out, OF);
            end else begin
                $display("FAIL %s: out=%h OF=%b, expected out=%h OF=%b",
                         e.name, out, OF, e.exp_out, e.exp_of);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        n_checks = 0;
        n_pass   = 0;

        // Reset held for two edges, then release with the same operands.
        drive(1'b0, 32'h12345678, 32'h1, 1'b0, 1'b0, "reset_0");
        drive(1'b0, 32'h12345678, 32'h1, 1'b0, 1'b0, "reset_1");
        drive(1'b1, 32'h12345678, 32'h1, 1'b0, 1'b0, "after_reset");

        // Directed corners.
        drive(1'b1, 32'hFFFFFFFF, 32'h0,        1'b0, 1'b1, "s_add_neg1_0");
        drive(1'b1, 32'hFFFFFFFF, 32'h1,        1'b0, 1'b0, "u_add_wrap");
        drive(1'b1, 32'h7FFFFFFF, 32'h1,        1'b0, 1'b1, "s_add_pos_ovf");
        drive(1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b1, "s_add_neg_ovf");
        drive(1'b1, 32'h0,        32'h1,        1'b1, 1'b0, "u_sub_borrow");
        drive(1'b1, 32'h5,        32'h5,        1'b1, 1'b0, "u_sub_equal");
        drive(1'b1, 32'h80000000, 32'h1,        1'b1, 1'b1, "s_sub_neg_ovf");
        drive(1'b1, 32'h7FFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, "s_sub_pos_ovf");
        drive(1'b1, 32'h80000000, 32'h80000000, 1'b1, 1'b1, "s_sub_min_min");
        drive(1'b1, 32'hDEADBEEF, 32'h0,        1'b1, 1'b0, "u_sub_zero");
        drive(1'b1, 32'h0,        32'h0,        1'b1, 1'b0, "u_sub_zero_zero");
        drive(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, "u_add_max_max");

        // Random regression, back-to-back, 100 per {FS,SF} combination.
        for (int combo = 0; combo < 4; combo++) begin
            for (int i = 0; i < 100; i++) begin
                ra = $urandom;
                rb = $urandom;
                if (i % 10 == 0) ra = {ra[31], {31{~ra[31]}}};
                drive(1'b1, ra, rb, combo[0], combo[1], $sformatf("rand_fs%0d_sf%0d", combo[0], combo[1]));
            end
        end

        // Alternating add/sub with new operands every edge.
        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            rb = $urandom;
            drive(1'b1, ra, rb, i[0], i[1], "pipe_alt");
        end

        // Reset in the middle of a stream drops the in-flight sample.
        drive(1'b1, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 1'b1, "pre_midreset");
        drive(1'b0, 32'hFFFFFFFF, 32'h1,        1'b0, 1'b0, "midreset");
        drive(1'b1, 32'h00000010, 32'h00000020, 1'b1, 1'b0, "post_midreset");

        // Let the last expectations drain.
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        n_checks++;
        if (exp_q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
